uart_frame_rx: RTL and testbench

- Receive-side frame decoder on the UART byte stream of the Duck Hunt inter-board link.
- Drains bytes from the uart receive FIFO (rx_empty / r_data / rd_uart).
- Frame format: sync byte, then PAYLOAD_BYTES payload bytes, then an XOR checksum byte.
- Publishes each verified payload as a wide register with a one-cycle valid strobe for the game logic.
- Malformed or stalled frames raise an error strobe; the decoder then resynchronises.

---
 rtl/uart_frame_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: frame decoder for the Duck Hunt inter-board UART link.
// It pops bytes from the UART receive FIFO whenever the FIFO has data.
// A frame is: sync byte, PAYLOAD_BYTES payload bytes, then an XOR checksum.
// A good frame updates payload and pulses payload_valid for one cycle.
// A bad checksum or an inter-byte timeout pulses frame_err for one cycle.
// Optional: define UART_FRAME_STATS_EN to add frames_ok/frames_err counters.

// One payload byte lane: a stage of the shift register plus its published copy.
module uart_frame_rx_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       load_en,
  input  logic [7:0] shift_in,
  output logic [7:0] shift_q,
  output logic [7:0] payload_q
);

  // Shift the stage while collecting; copy it out when the frame checks good.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      payload_q <= '0;
    end else begin
      if (clr)           shift_q <= '0;
      else if (shift_en) shift_q <= shift_in;
      if (load_en)       payload_q <= shift_q;
    end
  end

endmodule

module uart_frame_rx #(
  parameter int         PAYLOAD_BYTES  = 4,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 200000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_empty,
  input  logic [7:0]                 r_data,
  output logic                       rd_uart,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       payload_valid,
  output logic                       frame_err
`ifdef UART_FRAME_STATS_EN
 ,output logic [15:0]                frames_ok,
  output logic [15:0]                frames_err
`endif
);

  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         csum;
  logic [CNT_W-1:0]   tcnt;

  logic               accept;
  logic               sync_hit;
  logic               tmo_hit;
  logic               shift_en;
  logic               load_en;
  logic               clr;

  logic [PAYLOAD_BYTES-1:0][7:0] lane_in;
  logic [PAYLOAD_BYTES-1:0][7:0] shift_q;
  logic [PAYLOAD_BYTES-1:0][7:0] payload_q;

  // The decoder never stalls, so any byte at the FIFO head is taken.
  assign rd_uart  = !rx_empty && rst_n;
  assign accept   = !rx_empty;

  // A byte in the same cycle as the last timeout count wins over the timeout.
  assign sync_hit = (state == HUNT) && accept && (r_data == SYNC_BYTE);
  assign tmo_hit  = (state != HUNT) && !accept && (tcnt == TMO_LAST);
  assign shift_en = (state == PAYLOAD) && accept;
  assign load_en  = (state == CHECK) && accept && (r_data == csum);
  assign clr      = sync_hit || tmo_hit;

  // Lane 0 takes the new byte, so the first byte of a frame ends up in the MSBs.
  for (genvar i = 0; i < PAYLOAD_BYTES; i++) begin : g_lane
    if (i == 0) begin : g_head
      assign lane_in[i] = r_data;
    end else begin : g_tail
      assign lane_in[i] = shift_q[i-1];
    end

    uart_frame_rx_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .shift_en  (shift_en),
      .load_en   (load_en),
      .shift_in  (lane_in[i]),
      .shift_q   (shift_q[i]),
      .payload_q (payload_q[i])
    );
  end

  assign payload = payload_q;

  // Frame FSM: hunt for sync, collect payload with running XOR, judge checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      idx           <= '0;
      csum          <= '0;
      tcnt          <= '0;
      payload_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      payload_valid <= 1'b0;
      frame_err     <= 1'b0;
      case (state)
        HUNT: begin
          tcnt <= '0;
          if (sync_hit) begin
            state <= PAYLOAD;
            idx   <= '0;
            csum  <= '0;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            tcnt <= '0;
            csum <= csum ^ r_data;
            if (idx == IDX_LAST) state <= CHECK;
            else                 idx   <= idx + 1'b1;
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            state     <= HUNT;
            idx       <= '0;
            csum      <= '0;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CHECK: begin
          if (accept) begin
            if (r_data == csum) payload_valid <= 1'b1;
            else                frame_err     <= 1'b1;
            state <= HUNT;
            idx   <= '0;
            csum  <= '0;
            tcnt  <= '0;
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            state     <= HUNT;
            idx       <= '0;
            csum      <= '0;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state <= HUNT;
          idx   <= '0;
          csum  <= '0;
          tcnt  <= '0;
        end
      endcase
    end
  end

`ifdef UART_FRAME_STATS_EN
  // Saturating frame counters, stepped by the registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_ok  <= '0;
      frames_err <= '0;
    end else begin
      if (payload_valid && (frames_ok != 16'hFFFF))  frames_ok  <= frames_ok + 16'd1;
      if (frame_err     && (frames_err != 16'hFFFF)) frames_err <= frames_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed frames from the test plan followed by a
// randomized byte stream, checked every cycle against a frame-level model.
module tb_uart_frame_rx;

  localparam int         PB   = 4;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 24;

  logic          clk;
  logic          rst_n;
  logic          rx_empty;
  logic [7:0]    r_data;
  logic          rd_uart;
  logic [31:0]   payload;
  logic          payload_valid;
  logic          frame_err;
`ifdef UART_FRAME_STATS_EN
  logic [15:0]   frames_ok;
  logic [15:0]   frames_err;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: frame in progress, bytes collected, idle edges since last byte.
  bit          m_in;
  logic [7:0]  m_frm[$];
  int          m_idle;
  logic [31:0] m_payload;
  bit          m_valid;
  bit          m_err;
  int          m_ok;
  int          m_bad;

  uart_frame_rx #(
    .PAYLOAD_BYTES  (PB),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_empty      (rx_empty),
    .r_data        (r_data),
    .rd_uart       (rd_uart),
    .payload       (payload),
    .payload_valid (payload_valid),
    .frame_err     (frame_err)
`ifdef UART_FRAME_STATS_EN
   ,.frames_ok     (frames_ok),
    .frames_err    (frames_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xor4(input logic [31:0] pl);
    return pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
  endfunction

  task automatic model_reset();
    m_in      = 1'b0;
    m_frm.delete();
    m_idle    = 0;
    m_payload = '0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
    m_ok      = 0;
    m_bad     = 0;
  endtask

  // Frame-level rules: sync opens a frame, PB data bytes, then checksum verdict;
  // TMO consecutive idle edges inside a frame abandon it.
  task automatic model_edge(input bit acc, input logic [7:0] b);
    logic [7:0]  x;
    logic [31:0] pk;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (acc) begin
      m_idle = 0;
      if (!m_in) begin
        if (b == SYNC) begin
          m_in = 1'b1;
          m_frm.delete();
        end
      end else if (m_frm.size() < PB) begin
        m_frm.push_back(b);
      end else begin
        x  = '0;
        pk = '0;
        foreach (m_frm[i]) begin
          x  = x ^ m_frm[i];
          pk = {pk[23:0], m_frm[i]};
        end
        if (x == b) begin
          m_payload = pk;
          m_valid   = 1'b1;
          m_ok++;
        end else begin
          m_err = 1'b1;
          m_bad++;
        end
        m_in = 1'b0;
      end
    end else if (m_in) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_err = 1'b1;
        m_bad++;
        m_in  = 1'b0;
      end
    end
  endtask

  // One clock: present a byte (or nothing), then compare all outputs after the edge.
  task automatic cyc(input bit have, input logic [7:0] b);
    @(negedge clk);
    rx_empty = !have;
    r_data   = have ? b : 8'($urandom);
    #1;
    check("rd_uart", {31'd0, rd_uart}, {31'd0, have});
    @(posedge clk);
    model_edge(have, b);
    #1;
    check("payload_valid", {31'd0, payload_valid}, {31'd0, m_valid});
    check("frame_err", {31'd0, frame_err}, {31'd0, m_err});
    check("payload", payload, m_payload);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
  endtask

  task automatic frame(input logic [31:0] pl, input logic [7:0] ck, input int gap);
    cyc(1'b1, SYNC);
    idle(gap);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, pl[31-8*k -: 8]);
      idle(gap);
    end
    cyc(1'b1, ck);
  endtask

  function automatic int rgap();
    if ($urandom_range(0, 9) == 0) return TMO - 2 + int'($urandom_range(0, 3));
    return int'($urandom_range(0, 2));
  endfunction

  task automatic frame_rand(input logic [31:0] pl, input logic [7:0] ck);
    cyc(1'b1, SYNC);
    for (int k = 0; k < 4; k++) begin
      idle(rgap());
      cyc(1'b1, pl[31-8*k -: 8]);
    end
    idle(rgap());
    cyc(1'b1, ck);
  endtask

  // Hold reset for n cycles with a byte waiting; nothing may be popped.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n    = 1'b0;
    rx_empty = 1'b0;
    r_data   = 8'h33;
    model_reset();
    #1;
    check("rst_rd_uart", {31'd0, rd_uart}, 32'd0);
    check("rst_payload", payload, 32'd0);
    check("rst_valid", {31'd0, payload_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("rst_hold_rd_uart", {31'd0, rd_uart}, 32'd0);
      check("rst_hold_payload", payload, 32'd0);
    end
    rst_n    = 1'b1;
    rx_empty = 1'b1;
  endtask

  initial begin
    logic [31:0] pl;
    logic [7:0]  ck;
    int          sel;
    rst_n    = 1'b0;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    model_reset();

    do_reset(2);
`ifdef UART_FRAME_STATS_EN
    check("rst_frames_ok", {16'd0, frames_ok}, 32'd0);
    check("rst_frames_err", {16'd0, frames_err}, 32'd0);
`endif
    idle(2);

    // Basic back-to-back frame.
    frame(32'h11223344, 8'h44, 0);
    idle(1);
    check("dir_payload_basic", payload, 32'h11223344);

    // Bad checksum keeps the previous payload; next good frame is taken.
    frame(32'h11223344, 8'h45, 0);
    check("dir_bad_csum_hold", payload, 32'h11223344);
    frame(32'hCAFE0102, xor4(32'hCAFE0102), 0);
    idle(1);
    check("dir_after_bad", payload, 32'hCAFE0102);

    // Leading junk is discarded silently.
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'hFF);
    cyc(1'b1, 8'h5A);
    frame(32'h01020304, 8'h04, 0);
    idle(1);
    check("dir_junk_then_frame", payload, 32'h01020304);

    // Timeout mid-frame, then recovery.
    cyc(1'b1, SYNC);
    cyc(1'b1, 8'h11);
    cyc(1'b1, 8'h22);
    idle(TMO - 1);
    check("dir_tmo_not_yet", {31'd0, frame_err}, 32'd0);
    idle(1);
    check("dir_tmo_fire", {31'd0, frame_err}, 32'd1);
    idle(2);
    frame(32'h0A0B0C0D, xor4(32'h0A0B0C0D), 0);
    idle(1);
    check("dir_after_tmo", payload, 32'h0A0B0C0D);

    // Gaps just under the timeout never raise an error.
    frame(32'h55667788, xor4(32'h55667788), TMO - 2);
    idle(1);
    check("dir_gap_tmo_m2", payload, 32'h55667788);
    frame(32'h99AABBCC, xor4(32'h99AABBCC), TMO - 1);
    idle(1);
    check("dir_gap_tmo_m1", payload, 32'h99AABBCC);

    // Reset mid-frame discards the partial frame.
    cyc(1'b1, SYNC);
    cyc(1'b1, 8'h11);
    do_reset(3);
    cyc(1'b1, 8'h33);
    cyc(1'b1, 8'h44);
    cyc(1'b1, 8'h0F);
    idle(2);
    check("dir_post_reset_payload", payload, 32'd0);

    // Two good frames back-to-back, second carries sync values as data.
    frame(32'h11223344, 8'h44, 0);
    frame(32'hA5A5A5A5, 8'h00, 0);
    idle(2);
    check("dir_sync_as_data", payload, 32'hA5A5A5A5);
`ifdef UART_FRAME_STATS_EN
    check("dir_frames_ok", {16'd0, frames_ok}, 32'd2);
    check("dir_frames_err", {16'd0, frames_err}, 32'd0);
`endif

    // Randomized stream: junk, good frames, corrupted frames, random gaps.
    for (int it = 0; it < 150; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2) begin
        cyc(1'b1, 8'($urandom));
      end else begin
        pl = $urandom;
        ck = xor4(pl);
        if (sel == 2) ck = ck ^ 8'(1 << $urandom_range(0, 7));
        frame_rand(pl, ck);
      end
      idle(int'($urandom_range(0, 2)));
    end
    idle(TMO + 2);
`ifdef UART_FRAME_STATS_EN
    check("rnd_frames_ok", {16'd0, frames_ok}, 32'(m_ok));
    check("rnd_frames_err", {16'd0, frames_err}, 32'(m_bad));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
